// File: rtl/ahb2apb_pkg.sv
// Shared encodings and FSM state type for the AHB-Lite to APB3 bridge.
package ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StErr
  } state_e;

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are answered with zero-wait OKAY.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ahb2apb_psel_decode.sv
// Combinational decode of the slave index field into a one-hot APB select and a valid flag.
module ahb2apb_psel_decode #(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [IDX_W-1:0]   idx_i,
  output logic [NUM_SLV-1:0] psel_o,
  output logic               valid_o
);

  always_comb begin
    psel_o  = '0;
    valid_o = (NUM_SLV == 1) || (32'(idx_i) < NUM_SLV);
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if ((NUM_SLV == 1) || (32'(idx_i) == i)) begin
        psel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave turning each accepted transfer into one APB3 transfer.
// Define AHB2APB_ERR_RESP_EN to map pslverr and undecoded addresses onto an AHB ERROR response.
module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SLV_SEL_LSB = 12
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      hsel,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [DATA_W-1:0]         hwdata,
  input  logic                      hready_in,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [DATA_W-1:0]         hrdata,
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [NUM_SLV-1:0]  sel_q;
  logic                hreadyout_q;
  logic                hresp_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;

  logic [NUM_SLV-1:0]  dec_psel;
  logic                dec_valid;
  logic                accept;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic                sel_err;

  ahb2apb_psel_decode #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IdxW)
  ) u_decode (
    .idx_i   (haddr[SLV_SEL_LSB +: IdxW]),
    .psel_o  (dec_psel),
    .valid_o (dec_valid)
  );

  assign accept = hsel && hready_in && htrans_active(htrans) && hreadyout_q;

  // The captured select is one-hot, so an AND-OR mux picks the active slave's response.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
        sel_ready = sel_ready | pready[i];
        sel_err   = sel_err | pslverr[i];
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      write_q     <= 1'b0;
      sel_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hreadyout_q <= 1'b1;
          hresp_q     <= RESP_OKAY;
          if (accept) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            sel_q   <= dec_psel;
            if (!dec_valid) begin
`ifdef AHB2APB_ERR_RESP_EN
              hreadyout_q <= 1'b0;
              hresp_q     <= RESP_ERROR;
              state_q     <= StErr;
`else
              if (!hwrite) begin
                hrdata_q <= '0;
              end
`endif
            end else if (hwrite) begin
              hreadyout_q <= 1'b0;
              state_q     <= StWdata;
            end else begin
              hreadyout_q <= 1'b0;
              psel_q      <= dec_psel;
              paddr_q     <= haddr;
              pwrite_q    <= 1'b0;
              state_q     <= StSetup;
            end
          end
        end
        StWdata: begin
          pwdata_q <= hwdata;
          psel_q   <= sel_q;
          paddr_q  <= addr_q;
          pwrite_q <= write_q;
          state_q  <= StSetup;
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (sel_ready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
`ifdef AHB2APB_ERR_RESP_EN
            if (sel_err) begin
              hresp_q <= RESP_ERROR;
              state_q <= StErr;
            end else
`endif
            begin
              if (!write_q) begin
                hrdata_q <= sel_rdata;
              end
              hreadyout_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StErr: begin
          hreadyout_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

  // Every size is treated as a word transfer.
  logic unused_hsize;
  assign unused_hsize = ^hsize;
`ifndef AHB2APB_ERR_RESP_EN
  logic unused_sel_err;
  assign unused_sel_err = sel_err;
`endif

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge: vector table plus hand sequences for error and reset.
module tb_ahb2apb_bridge;
  import ahb2apb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic             hsel;
  logic [AW-1:0]    haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [DW-1:0]    hwdata;
  logic             hready_in;
  logic             hreadyout;
  logic             hresp;
  logic [DW-1:0]    hrdata;
  logic [AW-1:0]    paddr;
  logic [NS-1:0]    psel;
  logic             penable;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]    pready;
  logic [NS-1:0]    pslverr;

  ahb2apb_bridge dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready_in (hready_in),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rd;
    int          exp_wait;
  } vec_t;

  int          n_vec;
  int          n_err;
  logic [31:0] last_rd;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  vec_t        vecs [14];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic idle_prdata();
    for (int i = 0; i < NS; i++) begin
      prdata[i*DW +: DW] = {16'hBAD0, 16'(i)};
    end
  endtask

  // Starts at a negedge with hreadyout high; returns at the negedge where hreadyout is high again.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int delay, input logic [31:0] exp_rd,
                      input int exp_wait);
    int            low_cnt;
    int            setup_cnt;
    int            acc_cnt;
    int            sidx;
    bit            done;
    logic [NS-1:0] exp_sel;
    sidx      = int'(addr[13:12]);
    exp_sel   = NS'(1) << sidx;
    low_cnt   = 0;
    setup_cnt = 0;
    acc_cnt   = 0;
    done      = 1'b0;
    check($sformatf("%s hready_t0", tag), 32'(hreadyout), 32'd1);
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    haddr  = addr;
    hsize  = 3'd2;
    @(negedge hclk);
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      pready  = '0;
      pslverr = '0;
      idle_prdata();
      if (hreadyout) begin
        done = 1'b1;
      end else begin
        low_cnt++;
        if (psel != '0 && !penable) begin
          setup_cnt++;
          check($sformatf("%s setup_psel", tag), 32'(psel), 32'(exp_sel));
          check($sformatf("%s paddr", tag), paddr, addr);
          check($sformatf("%s pwrite", tag), 32'(pwrite), 32'(wr));
          if (wr) check($sformatf("%s pwdata", tag), pwdata, wdata);
        end else if (psel != '0) begin
          acc_cnt++;
          check($sformatf("%s access_psel", tag), 32'(psel), 32'(exp_sel));
          if (acc_cnt == delay + 1) begin
            if (wr) slv_mem[paddr] = pwdata;
            else prdata[sidx*DW +: DW] = slv_rd(paddr);
            pready = psel;
          end
        end
      end
      if (!done) @(negedge hclk);
    end
    check($sformatf("%s timeout", tag), 32'(done), 32'd1);
    check($sformatf("%s wait_cycles", tag), 32'(low_cnt), 32'(exp_wait));
    check($sformatf("%s setup_cycles", tag), 32'(setup_cnt), 32'd1);
    check($sformatf("%s access_cycles", tag), 32'(acc_cnt), 32'(delay + 1));
    check($sformatf("%s psel_end", tag), 32'({psel, penable}), 32'd0);
    check($sformatf("%s hresp", tag), 32'(hresp), 32'(RESP_OKAY));
    if (!wr) begin
      check($sformatf("%s hrdata", tag), hrdata, exp_rd);
      last_rd = exp_rd;
    end else begin
      check($sformatf("%s hrdata_hold", tag), hrdata, last_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    int          dly;

    n_vec = 0;
    n_err = 0;
    last_rd = '0;
    hreset_n = 1'b0;
    hsel = 1'b0;
    haddr = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize = 3'd2;
    hwdata = '0;
    hready_in = 1'b1;
    pready = '0;
    pslverr = '0;
    idle_prdata();
    slv_mem[32'h0000_1008] = 32'h1234_5678;
    ref_mem[32'h0000_1008] = 32'h1234_5678;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hA5A5_5A5A, 0, 32'h0, 3};
    vecs[1]  = '{1'b0, 32'h0000_1008, 32'h0, 0, 32'h1234_5678, 2};
    vecs[2]  = '{1'b1, 32'h0000_1000, 32'hC0DE_0000, 0, 32'h0, 3};
    vecs[3]  = '{1'b1, 32'h0000_1004, 32'hC0DE_1111, 1, 32'h0, 4};
    vecs[4]  = '{1'b1, 32'h0000_1008, 32'hC0DE_2222, 2, 32'h0, 5};
    vecs[5]  = '{1'b1, 32'h0000_100C, 32'hC0DE_3333, 3, 32'h0, 6};
    vecs[6]  = '{1'b1, 32'h0000_1010, 32'hC0DE_4444, 4, 32'h0, 7};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0, 4, 32'hC0DE_0000, 6};
    vecs[8]  = '{1'b0, 32'h0000_1004, 32'h0, 3, 32'hC0DE_1111, 5};
    vecs[9]  = '{1'b0, 32'h0000_1008, 32'h0, 2, 32'hC0DE_2222, 4};
    vecs[10] = '{1'b0, 32'h0000_100C, 32'h0, 1, 32'hC0DE_3333, 3};
    vecs[11] = '{1'b0, 32'h0000_1010, 32'h0, 0, 32'hC0DE_4444, 2};
    vecs[12] = '{1'b0, 32'h0000_0004, 32'h0, 0, 32'hA5A5_5A5A, 2};
    vecs[13] = '{1'b0, 32'h0000_2010, 32'h0, 1, 32'h5A5A_2010, 3};

    repeat (2) @(negedge hclk);
    check("rst hreadyout", 32'(hreadyout), 32'd1);
    check("rst hresp", 32'(hresp), 32'd0);
    check("rst hrdata", hrdata, 32'd0);
    check("rst paddr", paddr, 32'd0);
    check("rst psel", 32'(psel), 32'd0);
    check("rst penable", 32'(penable), 32'd0);
    check("rst pwrite", 32'(pwrite), 32'd0);
    check("rst pwdata", pwdata, 32'd0);
    hreset_n = 1'b1;
    @(negedge hclk);

    // IDLE/BUSY, deselected and bus-stalled requests must not start an APB transfer.
    hsel = 1'b1;
    htrans = HTRANS_BUSY;
    @(negedge hclk);
    check("busy hreadyout", 32'(hreadyout), 32'd1);
    check("busy psel", 32'(psel), 32'd0);
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("idle hreadyout", 32'(hreadyout), 32'd1);
    check("idle psel", 32'(psel), 32'd0);
    hsel = 1'b0;
    htrans = HTRANS_NONSEQ;
    @(negedge hclk);
    check("nosel hreadyout", 32'(hreadyout), 32'd1);
    check("nosel psel", 32'(psel), 32'd0);
    hsel = 1'b1;
    hready_in = 1'b0;
    @(negedge hclk);
    check("stall hreadyout", 32'(hreadyout), 32'd1);
    check("stall psel", 32'(psel), 32'd0);
    hsel = 1'b0;
    htrans = HTRANS_IDLE;
    hready_in = 1'b1;
    @(negedge hclk);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
           vecs[i].exp_rd, vecs[i].exp_wait);
    end

    for (int i = 0; i < 10; i++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 2);
      d   = $urandom;
      dly = int'($urandom_range(0, 10));
      xfer($sformatf("rnd%0d", i), wr, a, d, dly, ref_rd(a), (wr ? 3 : 2) + dly);
      if (wr) ref_mem[a] = d;
    end

    // Slave 2 answers with pslverr on its first ACCESS cycle.
    hsel = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b0;
    haddr = 32'h0000_2000;
    @(negedge hclk);
    hsel = 1'b0;
    htrans = HTRANS_IDLE;
    check("err setup_psel", 32'({psel, penable}), 32'({4'b0100, 1'b0}));
    @(negedge hclk);
    check("err access_psel", 32'({psel, penable}), 32'({4'b0100, 1'b1}));
    pready = 4'b0100;
    pslverr = 4'b0100;
    prdata[2*DW +: DW] = 32'hE770_0002;
    @(negedge hclk);
    pready = '0;
    pslverr = '0;
    idle_prdata();
    check("err psel_end", 32'({psel, penable}), 32'd0);
`ifdef AHB2APB_ERR_RESP_EN
    check("err c1 hresp", 32'(hresp), 32'd1);
    check("err c1 hreadyout", 32'(hreadyout), 32'd0);
    @(negedge hclk);
    check("err c2 hresp", 32'(hresp), 32'd1);
    check("err c2 hreadyout", 32'(hreadyout), 32'd1);
    check("err hrdata_hold", hrdata, last_rd);
    @(negedge hclk);
    check("err after hresp", 32'(hresp), 32'd0);
`else
    check("noerr hresp", 32'(hresp), 32'd0);
    check("noerr hreadyout", 32'(hreadyout), 32'd1);
    check("noerr hrdata", hrdata, 32'hE770_0002);
    last_rd = 32'hE770_0002;
    @(negedge hclk);
    check("noerr after hresp", 32'(hresp), 32'd0);
`endif

    // Reset asserted while slave 3 is stalling in ACCESS.
    hsel = 1'b1;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b0;
    haddr = 32'h0000_3040;
    @(negedge hclk);
    hsel = 1'b0;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("rstx access", 32'({psel, penable}), 32'({4'b1000, 1'b1}));
    hreset_n = 1'b0;
    #1;
    check("rstx psel", 32'(psel), 32'd0);
    check("rstx penable", 32'(penable), 32'd0);
    check("rstx hreadyout", 32'(hreadyout), 32'd1);
    check("rstx hrdata", hrdata, 32'd0);
    last_rd = '0;
    @(negedge hclk);
    hreset_n = 1'b1;
    @(negedge hclk);
    xfer("rstx_rd", 1'b0, 32'h0000_3040, 32'h0, 2, 32'h5A5A_3040, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
